// File: rtl/system_pio_pkg.sv
// Shared definitions for the Avalon-MM PIO slaves: register word addresses and edge-capture modes.
package system_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA     = 2'd0;
  localparam logic [1:0] PIO_ADDR_RESERVED = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP  = 2'd3;

  typedef enum int unsigned {
    EDGE_RISING  = 0,
    EDGE_FALLING = 1,
    EDGE_ANY     = 2
  } edge_type_e;

endpackage

// File: rtl/pio_bit_conditioner.sv
// One input bit: two-flop synchroniser followed by an optional stable-count debounce filter.
module pio_bit_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter logic        RESET_VALUE     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic debounced
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign debounced = sync2;
    end else begin : g_debounce
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] cnt;
      logic          deb_q;

      // Counter only advances while the synced bit disagrees, so it never passes DEBOUNCE_CYCLES-1.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt   <= '0;
          deb_q <= RESET_VALUE;
        end else if (sync2 == deb_q) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt   <= '0;
          deb_q <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign debounced = deb_q;
    end
  endgenerate

endmodule

// File: rtl/system_key_pio_in.sv
// Avalon-MM input PIO: conditioned key inputs, edge capture register and maskable level interrupt.
module system_key_pio_in
  import system_pio_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH      = 4,
  parameter int unsigned            EDGE_TYPE       = 1,
  parameter int unsigned            DEBOUNCE_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE     = '1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] edge_prev;
  logic [DATA_WIDTH-1:0] edge_event;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] w1c;
  logic                  rd_en;
  logic                  wr_en;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      pio_bit_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (RESET_VALUE[gi])
      ) u_cond (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_bit    (in_port[gi]),
        .debounced (data_in[gi])
      );
    end
  endgenerate

  assign rd_en = chipselect & ~read_n;
  assign wr_en = chipselect & ~write_n;

  always_comb begin
    edge_event = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_event = ~edge_prev & data_in;
      EDGE_FALLING: edge_event = edge_prev & ~data_in;
      default:      edge_event = edge_prev ^ data_in;
    endcase
  end

  always_comb begin
    w1c = '0;
    if (wr_en && address == PIO_ADDR_EDGECAP) w1c = writedata[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_prev    <= RESET_VALUE;
      edge_capture <= '0;
      irq_mask     <= '0;
      irq          <= 1'b0;
    end else begin
      edge_prev <= data_in;
      // A new event is OR-ed in after the clear so it survives a same-cycle W1C.
      edge_capture <= (edge_capture & ~w1c) | edge_event;
      if (wr_en && address == PIO_ADDR_IRQMASK) irq_mask <= writedata[DATA_WIDTH-1:0];
      irq <= |(edge_capture & irq_mask);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd_en) begin
      case (address)
        PIO_ADDR_DATA:    readdata <= 32'(data_in);
        PIO_ADDR_IRQMASK: readdata <= 32'(irq_mask);
        PIO_ADDR_EDGECAP: readdata <= 32'(edge_capture);
        default:          readdata <= '0;
      endcase
    end else begin
      readdata <= '0;
    end
  end

endmodule

// File: tb/tb_system_key_pio_in.sv
// Directed bench: one falling-edge instance without debounce and one with an 8-cycle debounce.
module tb_system_key_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs0, cs8;
  logic        read_n, write_n;
  logic [31:0] writedata;
  logic [3:0]  in0, in8;
  logic [31:0] rd0, rd8;
  logic        irq0, irq8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  system_key_pio_in #(
    .DATA_WIDTH      (4),
    .EDGE_TYPE       (1),
    .DEBOUNCE_CYCLES (0),
    .RESET_VALUE     (4'hF)
  ) dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (cs0),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in0),
    .readdata   (rd0),
    .irq        (irq0)
  );

  system_key_pio_in #(
    .DATA_WIDTH      (4),
    .EDGE_TYPE       (1),
    .DEBOUNCE_CYCLES (8),
    .RESET_VALUE     (4'hF)
  ) dut8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (cs8),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in8),
    .readdata   (rd8),
    .irq        (irq8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 32'h%08h expected 32'h%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    cs0 = (d == 0); cs8 = (d != 0);
    address = a; writedata = v; write_n = 1'b0;
    @(negedge clk);
    cs0 = 1'b0; cs8 = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input int d, input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    cs0 = (d == 0); cs8 = (d != 0);
    address = a; read_n = 1'b0;
    @(negedge clk);
    cs0 = 1'b0; cs8 = 1'b0; read_n = 1'b1;
    v = (d == 0) ? rd0 : rd8;
  endtask

  logic [31:0] r;

  initial begin
    reset_n = 1'b0; address = '0; cs0 = 1'b0; cs8 = 1'b0;
    read_n = 1'b1; write_n = 1'b1; writedata = '0;
    in0 = 4'hF; in8 = 4'hF;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_readdata", rd0, 32'h0);
    check("reset_irq", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;
    bus_read(0, 2'd0, r);
    check("data_after_reset", r, 32'h0000000F);

    // Falling-edge capture and interrupt masking
    @(negedge clk); in0 = 4'hE;
    repeat (4) @(negedge clk);
    bus_read(0, 2'd3, r);
    check("edgecap_bit0", r, 32'h1);
    check("irq_masked", {31'b0, irq0}, 32'h0);
    bus_write(0, 2'd2, 32'h1);
    @(negedge clk);
    check("irq_unmasked", {31'b0, irq0}, 32'h1);
    bus_write(0, 2'd3, 32'h1);
    @(negedge clk);
    check("irq_after_w1c", {31'b0, irq0}, 32'h0);
    in0 = 4'hF;
    repeat (4) @(negedge clk);

    // Debounce filtering on bit2
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 3 == 0) in8[2] = ~in8[2];
    end
    bus_read(1, 2'd0, r);
    check("deb_data_bounce", r, 32'h0000000F);
    bus_read(1, 2'd3, r);
    check("deb_edgecap_bounce", r, 32'h0);
    in8 = 4'hB;
    repeat (12) @(negedge clk);
    bus_read(1, 2'd0, r);
    check("deb_data_settled", r, 32'h0000000B);
    bus_read(1, 2'd3, r);
    check("deb_edgecap_settled", r, 32'h4);

    // Same-cycle W1C and new event on bit0: event wins
    @(negedge clk); in0 = 4'hE;
    @(negedge clk);
    bus_write(0, 2'd3, 32'h1);
    bus_read(0, 2'd3, r);
    check("race_event_wins", r, 32'h1);
    bus_write(0, 2'd3, 32'h1);
    bus_read(0, 2'd3, r);
    check("w1c_no_event", r, 32'h0);
    in0 = 4'hF;
    repeat (4) @(negedge clk);

    // Read-only DATA, reserved word, masked IRQMASK width
    bus_write(0, 2'd0, 32'hFFFFFFFF);
    bus_write(0, 2'd1, 32'hFFFFFFFF);
    bus_read(0, 2'd0, r);
    check("data_write_ignored", r, 32'h0000000F);
    bus_read(0, 2'd1, r);
    check("reserved_reads_0", r, 32'h0);
    bus_write(0, 2'd2, 32'hFFFFFFFF);
    bus_read(0, 2'd2, r);
    check("irqmask_readback", r, 32'h0000000F);

    // Reset in the middle of pending captures
    @(negedge clk); in0 = 4'hA;
    repeat (4) @(negedge clk);
    in0 = 4'hF;
    repeat (4) @(negedge clk);
    bus_read(0, 2'd3, r);
    check("edgecap_0x5", r, 32'h5);
    check("irq_before_reset", {31'b0, irq0}, 32'h1);
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("irq_async_reset", {31'b0, irq0}, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    bus_read(0, 2'd3, r);
    check("edgecap_after_reset", r, 32'h0);
    bus_read(0, 2'd2, r);
    check("irqmask_after_reset", r, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
